// File: rtl/bit_serial_alu_ctrl_pkg.sv
// bit_serial_alu_ctrl_pkg: mode encodings, FSM states and decoder width shared by the serial ALU controller
package bit_serial_alu_ctrl_pkg;
  localparam logic [2:0] MODE_PLUS = 3'd0;
  localparam logic [2:0] MODE_AND  = 3'd1;
  localparam logic [2:0] MODE_OR   = 3'd2;
  localparam logic [2:0] MODE_XOR  = 3'd3;
  localparam logic [2:0] MODE_XNOR = 3'd4;
  localparam logic [2:0] MODE_MAX  = MODE_XNOR;
  localparam int DEC_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/bit_serial_alu_ctrl_decoder.sv
// alu_mode_decoder: 3-to-8 one-hot mode decoder (en, mode in; onehot out, all zero when en low)
module alu_mode_decoder
  import bit_serial_alu_ctrl_pkg::*;
(
  input  logic             en,
  input  logic [2:0]       mode,
  output logic [DEC_W-1:0] onehot
);
  assign onehot = en ? DEC_W'(1) << mode : '0;
endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: drives a 1-bit ALU slice LSB first (start/mode/opa/opb/cin in; busy/done/err/result/carry_out out; decoder_x/A/B/C_in to slice, X/C_out from slice)
module bit_serial_alu_ctrl
  import bit_serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [DEC_W-1:0] decoder_x,
  output logic             A,
  output logic             B,
  output logic             C_in,
  input  logic             X,
  input  logic             C_out
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [2:0] mode_q;
  logic [WIDTH-1:0] sha, shb, shr;
  logic carry_q;
  logic [CW-1:0] cnt;
  logic idle, run, last, go, bad;
  assign idle = state == S_IDLE;
  assign run = state == S_RUN;
  assign last = run && cnt == CW'(WIDTH - 1);
  assign go = idle && start && mode <= MODE_MAX;
  assign bad = idle && start && mode > MODE_MAX;
  assign busy = run;
  assign done = state == S_DONE;
  assign A = run & sha[0];
  assign B = run & shb[0];
  assign C_in = run && mode_q == MODE_PLUS && carry_q;
  alu_mode_decoder u_dec (
    .en(run),
    .mode(mode_q),
    .onehot(decoder_x)
  );
  always_comb begin
    state_n = go ? S_RUN : last ? S_DONE : done ? S_IDLE : state;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= '0;
      sha <= '0;
      shb <= '0;
      shr <= '0;
      carry_q <= 1'b0;
      cnt <= '0;
      result <= '0;
      carry_out <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= bad;
      if (go) begin
        sha <= opa;
        shb <= opb;
        mode_q <= mode;
        carry_q <= mode == MODE_PLUS && cin;
        cnt <= '0;
      end else if (run) begin
        sha <= sha >> 1;
        shb <= shb >> 1;
        shr <= {X, shr[WIDTH-1:1]};
        carry_q <= mode_q == MODE_PLUS && C_out;
        cnt <= cnt + 1'b1;
        if (last) begin
          result <= {X, shr[WIDTH-1:1]};
          carry_out <= mode_q == MODE_PLUS && C_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb_bit_serial_alu_ctrl: randomized and directed checks of the serial ALU controller against a transaction-level model
module tb_bit_serial_alu_ctrl;
  localparam int W = 8;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic cin = 1'b0;
  logic [2:0] mode = '0;
  logic [W-1:0] opa = '0, opb = '0;
  logic busy, done, err, carry_out, A, B, C_in, X, C_out;
  logic [W-1:0] result;
  logic [7:0] decoder_x;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  always #5 CLK = ~CLK;
  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .opa(opa), .opb(opb), .cin(cin),
    .busy(busy), .done(done), .err(err), .result(result), .carry_out(carry_out),
    .decoder_x(decoder_x), .A(A), .B(B), .C_in(C_in), .X(X), .C_out(C_out)
  );
  always_comb begin
    X = 1'b0;
    C_out = 1'b0;
    if (decoder_x[0]) begin
      X = A ^ B ^ C_in;
      C_out = (A & B) | (A & C_in) | (B & C_in);
    end else if (decoder_x[1]) X = A & B;
    else if (decoder_x[2]) X = A | B;
    else if (decoder_x[3]) X = A ^ B;
    else if (decoder_x[4]) X = ~(A ^ B);
  end
  int busy_left = 0;
  bit in_done = 0, e_err = 0, ec = 0, e_cout = 0, p_cout = 0;
  logic [2:0] e_mode = '0;
  logic [W-1:0] ea = '0, eb = '0, e_res = '0, p_res = '0;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_left = 0;
      in_done = 0;
      e_err = 0;
      e_res = '0;
      e_cout = 0;
    end else begin
      e_err = 0;
      if (in_done) in_done = 0;
      else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          in_done = 1;
          e_res = p_res;
          e_cout = p_cout;
        end
      end else if (start) begin
        if (mode <= 3'd4) begin
          e_mode = mode;
          ea = opa;
          eb = opb;
          ec = (mode == 3'd0) && cin;
          busy_left = W;
          p_cout = 0;
          case (mode)
            3'd0: {p_cout, p_res} = {1'b0, ea} + {1'b0, eb} + (W + 1)'(ec);
            3'd1: p_res = ea & eb;
            3'd2: p_res = ea | eb;
            3'd3: p_res = ea ^ eb;
            default: p_res = ~(ea ^ eb);
          endcase
        end else e_err = 1;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  int idx;
  logic [W-1:0] msk;
  logic [W:0] part;
  logic e_a, e_b, e_c;
  always @(negedge CLK) begin
    if (chk_en) begin
      idx = W - busy_left;
      e_a = 0;
      e_b = 0;
      e_c = 0;
      if (busy_left > 0) begin
        e_a = ea[idx];
        e_b = eb[idx];
        msk = W'((1 << idx) - 1);
        part = {1'b0, ea & msk} + {1'b0, eb & msk} + (W + 1)'(ec);
        e_c = (e_mode == 3'd0) && part[idx];
      end
      chk("busy", busy, busy_left > 0);
      chk("done", done, in_done);
      chk("err", err, e_err);
      chk("decoder_x", decoder_x, busy_left > 0 ? 8'(1 << e_mode) : 8'h00);
      chk("result", result, e_res);
      chk("carry_out", carry_out, e_cout);
      chk("A", A, e_a);
      chk("B", B, e_b);
      chk("C_in", C_in, e_c);
    end
  end
  task automatic run_op(input logic [2:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] xr, input logic xc, input bit glitch);
    int n, nb;
    @(negedge CLK);
    start = 1;
    mode = md;
    opa = a;
    opb = b;
    cin = c;
    n = 0;
    nb = 0;
    while (n < 40) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        start = 0;
        mode = 3'($urandom_range(0, 7));
        opa = W'($urandom);
        opb = W'($urandom);
      end
      if (glitch && n == 3) begin
        start = 1;
        mode = 3'd1;
      end
      if (n == 4) start = 0;
      if (busy) nb++;
      if (done) break;
    end
    chk("done_latency", n, W + 1);
    chk("busy_cycles", nb, W);
    chk("lit_result", result, xr);
    chk("lit_carry", carry_out, xc);
  endtask
  task automatic err_op(input logic [W-1:0] prev);
    @(negedge CLK);
    start = 1;
    mode = 3'd6;
    @(negedge CLK);
    start = 0;
    chk("lit_err_pulse", err, 1);
    chk("lit_err_busy", busy, 0);
    chk("lit_err_result", result, prev);
    @(negedge CLK);
    chk("lit_err_clear", err, 0);
    chk("lit_err_busy2", busy, 0);
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_dec", decoder_x, 0);
    RST = 0;
    chk_en = 1;
    run_op(3'd0, 8'h5A, 8'h3C, 0, 8'h96, 0, 0);
    run_op(3'd0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
    run_op(3'd0, 8'hFF, 8'h00, 1, 8'h00, 1, 0);
    run_op(3'd1, 8'hF0, 8'h3C, 1, 8'h30, 0, 0);
    run_op(3'd2, 8'hF0, 8'h3C, 0, 8'hFC, 0, 0);
    run_op(3'd3, 8'hF0, 8'h3C, 1, 8'hCC, 0, 0);
    run_op(3'd4, 8'hF0, 8'h3C, 0, 8'h33, 0, 0);
    err_op(8'h33);
    run_op(3'd0, 8'h12, 8'h34, 1, 8'h47, 0, 1);
    @(negedge CLK);
    start = 1;
    mode = 3'd0;
    opa = 8'h77;
    opb = 8'h11;
    @(negedge CLK);
    start = 0;
    repeat (4) @(negedge CLK);
    #2 RST = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_dec", decoder_x, 0);
    chk("arst_A", A, 0);
    chk("arst_B", B, 0);
    chk("arst_result", result, 0);
    @(negedge CLK);
    RST = 0;
    run_op(3'd3, 8'hAA, 8'h55, 0, 8'hFF, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      start = $urandom_range(0, 3) == 0;
      mode = 3'($urandom_range(0, 7));
      opa = W'($urandom);
      opb = W'($urandom);
      cin = 1'($urandom);
    end
    start = 0;
    repeat (W + 3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
